// File: rtl/lfsr_arbiter.sv
// rtl/lfsr_arbiter.sv - round-robin ownership arbiter for a shared 6-bit LFSR
//
// Two requesters (bit0 = height gen, bit1 = gap gen) share one LFSR. A grant
// advances the LFSR STEPS times, samples it, and holds the sample until the
// owner acknowledges it. Reseed pulses are remembered while busy and turned
// into a single clear strobe once the arbiter is idle again.
// STEPS must lie in 1..15 because the step counter is 4 bits wide.

module lfsr_arbiter #(
  parameter int STEPS = 6
) (
  input  logic       clk,
  input  logic       aclr,
  input  logic [1:0] req,
  input  logic [1:0] ack,
  input  logic       reseed,
  input  logic [5:0] lfsr_q,
  output logic       lfsr_en,
  output logic       lfsr_clr,
  output logic [1:0] grant,
  output logic       rnd_valid,
  output logic [5:0] rnd_data,
  output logic       busy
);

  localparam logic [3:0] STEPS_L = 4'(STEPS);

  typedef enum logic [2:0] {
    S_IDLE,
    S_CLEAR,
    S_STEP,
    S_SAMPLE,
    S_HOLD
  } state_t;

  state_t     r_state;
  logic [3:0] r_cnt;
  logic       r_pend;
  logic       r_ptr;        // index of the requester served last
  logic [1:0] r_grant;
  logic       r_lfsr_en;
  logic       r_lfsr_clr;
  logic       r_rnd_valid;
  logic [5:0] r_rnd_data;

  state_t     w_state_nxt;
  logic [3:0] w_cnt_nxt;
  logic       w_pend_nxt;
  logic       w_ptr_nxt;
  logic [1:0] w_grant_nxt;
  logic       w_en_nxt;
  logic       w_clr_nxt;
  logic       w_valid_nxt;
  logic [5:0] w_data_nxt;
  logic [1:0] w_pick;
  logic       w_lost;
  logic       w_acked;

  // Round-robin pick: on a tie, the requester not served last wins.
  always_comb begin
    w_pick = req;
    if (req == 2'b11) begin
      w_pick = r_ptr ? 2'b01 : 2'b10;
    end
  end

  // Owner status: its request dropped, or it acknowledged the sample.
  always_comb begin
    w_lost  = ((r_grant & req) == 2'b00);
    w_acked = ((r_grant & ack) != 2'b00);
  end

  // Next-state and next-output decode; every next value defaults first.
  always_comb begin
    w_state_nxt = r_state;
    w_cnt_nxt   = r_cnt;
    w_pend_nxt  = r_pend;
    w_ptr_nxt   = r_ptr;
    w_grant_nxt = r_grant;
    w_en_nxt    = 1'b0;
    w_clr_nxt   = 1'b0;
    w_valid_nxt = 1'b0;
    w_data_nxt  = r_rnd_data;

    // A reseed seen while busy is parked until the arbiter returns to idle.
    if (reseed && (r_state != S_IDLE)) begin
      w_pend_nxt = 1'b1;
    end

    case (r_state)
      S_IDLE: begin
        if (reseed || r_pend) begin
          w_state_nxt = S_CLEAR;
          w_clr_nxt   = 1'b1;
        end else if (req != 2'b00) begin
          w_state_nxt = S_STEP;
          w_grant_nxt = w_pick;
          w_cnt_nxt   = STEPS_L;
          w_en_nxt    = 1'b1;
        end
      end

      // One clear cycle absorbs every reseed collected so far.
      S_CLEAR: begin
        w_state_nxt = S_IDLE;
        w_pend_nxt  = 1'b0;
      end

      S_STEP: begin
        if (w_lost) begin
          w_state_nxt = S_IDLE;
          w_grant_nxt = 2'b00;
          w_ptr_nxt   = r_grant[1];
          w_cnt_nxt   = 4'd0;
        end else if (r_cnt <= 4'd1) begin
          w_state_nxt = S_SAMPLE;
          w_cnt_nxt   = 4'd0;
        end else begin
          w_cnt_nxt = r_cnt - 4'd1;
          w_en_nxt  = 1'b1;
        end
      end

      // The LFSR is frozen here, so lfsr_q reflects exactly STEPS advances.
      S_SAMPLE: begin
        if (w_lost) begin
          w_state_nxt = S_IDLE;
          w_grant_nxt = 2'b00;
          w_ptr_nxt   = r_grant[1];
        end else begin
          w_state_nxt = S_HOLD;
          w_data_nxt  = lfsr_q;
          w_valid_nxt = 1'b1;
        end
      end

      S_HOLD: begin
        if (w_lost || w_acked) begin
          w_state_nxt = S_IDLE;
          w_grant_nxt = 2'b00;
          w_ptr_nxt   = r_grant[1];
        end else begin
          w_valid_nxt = 1'b1;
        end
      end

      default: begin
        w_state_nxt = S_IDLE;
        w_grant_nxt = 2'b00;
        w_cnt_nxt   = 4'd0;
      end
    endcase
  end

  // State and registered outputs; reset drops any in-flight grant silently.
  always_ff @(posedge clk or negedge aclr) begin
    if (!aclr) begin
      r_state     <= S_IDLE;
      r_cnt       <= 4'd0;
      r_pend      <= 1'b0;
      r_ptr       <= 1'b1;
      r_grant     <= 2'b00;
      r_lfsr_en   <= 1'b0;
      r_lfsr_clr  <= 1'b0;
      r_rnd_valid <= 1'b0;
      r_rnd_data  <= 6'd0;
    end else begin
      r_state     <= w_state_nxt;
      r_cnt       <= w_cnt_nxt;
      r_pend      <= w_pend_nxt;
      r_ptr       <= w_ptr_nxt;
      r_grant     <= w_grant_nxt;
      r_lfsr_en   <= w_en_nxt;
      r_lfsr_clr  <= w_clr_nxt;
      r_rnd_valid <= w_valid_nxt;
      r_rnd_data  <= w_data_nxt;
    end
  end

  assign lfsr_en   = r_lfsr_en;
  assign lfsr_clr  = r_lfsr_clr;
  assign grant     = r_grant;
  assign rnd_valid = r_rnd_valid;
  assign rnd_data  = r_rnd_data;
  assign busy      = (r_state != S_IDLE);

endmodule

// File: tb/tb_lfsr_arbiter.sv
// tb/tb_lfsr_arbiter.sv - self-checking bench for lfsr_arbiter

module tb_lfsr_arbiter;

  localparam int STEPS = 6;

  logic       clk = 1'b0;
  logic       aclr = 1'b0;
  logic [1:0] req = 2'b00;
  logic [1:0] ack = 2'b00;
  logic       reseed = 1'b0;
  logic [5:0] lfsr_q;
  logic       lfsr_en;
  logic       lfsr_clr;
  logic [1:0] grant;
  logic       rnd_valid;
  logic [5:0] rnd_data;
  logic       busy;

  // Shared LFSR environment driven by the arbiter's strobes.
  logic [5:0] env_lfsr = 6'd0;

  // Transaction-level reference state.
  logic [5:0] m_lfsr = 6'd0;
  logic [5:0] m_data = 6'd0;
  logic       m_ptr = 1'b1;
  logic       m_pend = 1'b0;

  int vectors = 0;
  int miscompares = 0;

  lfsr_arbiter #(.STEPS(STEPS)) dut (
    .clk       (clk),
    .aclr      (aclr),
    .req       (req),
    .ack       (ack),
    .reseed    (reseed),
    .lfsr_q    (lfsr_q),
    .lfsr_en   (lfsr_en),
    .lfsr_clr  (lfsr_clr),
    .grant     (grant),
    .rnd_valid (rnd_valid),
    .rnd_data  (rnd_data),
    .busy      (busy)
  );

  always #5 clk = ~clk;

  function automatic logic [5:0] lstep(input logic [5:0] v);
    return {v[4:0], ~(v[5] ^ v[4])};
  endfunction

  function automatic logic [5:0] stepn(input logic [5:0] v, input int n);
    logic [5:0] t;
    t = v;
    for (int k = 0; k < n; k++) t = lstep(t);
    return t;
  endfunction

  function automatic logic [1:0] arb(input logic [1:0] r, input logic last_bit1);
    if (r == 2'b11) return last_bit1 ? 2'b01 : 2'b10;
    return r;
  endfunction

  // External LFSR: clear wins, otherwise advance one step per enabled cycle.
  always @(posedge clk) begin
    if (lfsr_clr) env_lfsr <= 6'd0;
    else if (lfsr_en) env_lfsr <= lstep(env_lfsr);
  end
  assign lfsr_q = env_lfsr;

  initial begin
    #200000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  task automatic chk1(input string tag, input logic obs, input logic exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic chk2(input string tag, input logic [1:0] obs, input logic [1:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic chk6(input string tag, input logic [5:0] obs, input logic [5:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic inv();
    chk1("inv_en_clr", lfsr_en & lfsr_clr, 1'b0);
    chk1("inv_onehot0", $onehot0(grant), 1'b1);
    chk1("inv_valid_grant", rnd_valid & (grant == 2'b00), 1'b0);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
    inv();
  endtask

  task automatic check_idle(input string tag);
    chk2({tag, "_grant"}, grant, 2'b00);
    chk1({tag, "_valid"}, rnd_valid, 1'b0);
    chk1({tag, "_en"}, lfsr_en, 1'b0);
    chk1({tag, "_clr"}, lfsr_clr, 1'b0);
    chk1({tag, "_busy"}, busy, 1'b0);
    chk6({tag, "_data"}, rnd_data, m_data);
  endtask

  task automatic clear_seq();
    tick();
    chk1("clr_on", lfsr_clr, 1'b1);
    chk2("clr_grant", grant, 2'b00);
    chk1("clr_busy", busy, 1'b1);
    tick();
    chk1("clr_once", lfsr_clr, 1'b0);
    chk2("clr_after_grant", grant, 2'b00);
    chk1("clr_after_busy", busy, 1'b0);
    m_lfsr = 6'd0;
    m_pend = 1'b0;
  endtask

  // One grant from idle. Cycle i: 1..STEPS = STEP, STEPS+1 = SAMPLE,
  // STEPS+2 = first HOLD cycle. abort_at drops the owner's request in cycle
  // abort_at; rs1/rs2 pulse reseed in that STEP cycle.
  task automatic do_txn(input logic [1:0] r, input logic [1:0] g, input int abort_at,
                        input int rs1, input int rs2, input int hold_cycles);
    int adv;
    chk1("pre_busy", busy, 1'b0);
    req = r;
    tick();
    for (int i = 1; i <= STEPS + 2; i++) begin
      if (i > 1) tick();
      reseed = 1'b0;
      if (i <= STEPS) begin
        chk1("step_en", lfsr_en, 1'b1);
        chk1("step_valid", rnd_valid, 1'b0);
      end else if (i == STEPS + 1) begin
        chk1("sample_en", lfsr_en, 1'b0);
        chk1("sample_valid", rnd_valid, 1'b0);
        chk6("sample_data_kept", rnd_data, m_data);
      end else begin
        chk1("hold_en", lfsr_en, 1'b0);
        chk1("hold_valid", rnd_valid, 1'b1);
        chk6("hold_data", rnd_data, stepn(m_lfsr, STEPS));
      end
      chk2("txn_grant", grant, g);
      chk1("txn_busy", busy, 1'b1);
      if (i == abort_at) begin
        req = req & ~g;
        ack = 2'b00;
        tick();
        adv = (i < STEPS) ? i : STEPS;
        m_lfsr = stepn(m_lfsr, adv);
        if (i == STEPS + 2) m_data = m_lfsr;
        m_ptr = g[1];
        check_idle("abort");
        if (m_pend) clear_seq();
        return;
      end
      if (i == rs1 || i == rs2) begin
        reseed = 1'b1;
        m_pend = 1'b1;
      end
      ack = (i <= STEPS + 1) ? 2'($urandom_range(0, 3)) : 2'b00;
    end
    m_data = stepn(m_lfsr, STEPS);
    m_lfsr = m_data;
    for (int h = 0; h < hold_cycles; h++) begin
      ack = ($urandom_range(0, 1) == 1) ? (g ^ 2'b11) : 2'b00;
      tick();
      chk1("hold_stay_valid", rnd_valid, 1'b1);
      chk2("hold_stay_grant", grant, g);
      chk6("hold_stay_data", rnd_data, m_data);
    end
    ack = g;
    tick();
    ack = 2'b00;
    m_ptr = g[1];
    check_idle("ack");
    if (m_pend) clear_seq();
  endtask

  initial begin
    logic [1:0] r;
    int ab;
    int rs;

    // Reset state, then release.
    tick();
    check_idle("reset");
    aclr = 1'b1;
    tick();
    check_idle("post_reset");

    // Contention from reset: bit0 wins the first tie, then strict alternation.
    do_txn(2'b11, 2'b01, 0, 0, 0, 1);
    do_txn(2'b11, 2'b10, 0, 0, 0, 0);
    do_txn(2'b11, 2'b01, 0, 0, 0, 2);
    do_txn(2'b11, 2'b10, 0, 0, 0, 0);
    req = 2'b00;

    // Reseed in idle beats a simultaneous request.
    req = 2'b01;
    reseed = 1'b1;
    tick();
    reseed = 1'b0;
    chk1("idle_reseed_clr", lfsr_clr, 1'b1);
    chk2("idle_reseed_grant", grant, 2'b00);
    chk1("idle_reseed_busy", busy, 1'b1);
    tick();
    chk1("idle_reseed_clr_off", lfsr_clr, 1'b0);
    chk2("idle_reseed_grant2", grant, 2'b00);
    m_lfsr = 6'd0;

    // Single request from a zero seed, with stray acks on bit1 during HOLD.
    do_txn(2'b01, 2'b01, 0, 0, 0, 3);
    chk6("single_data_abs", m_data, stepn(6'd0, STEPS));
    req = 2'b00;

    // Two reseed pulses while busy collapse to one clear after HOLD.
    do_txn(2'b01, 2'b01, 0, 2, 4, 1);
    req = 2'b00;

    // Abort on the 3rd STEP cycle, then a tie goes to bit1.
    do_txn(2'b01, 2'b01, 3, 0, 0, 0);
    do_txn(2'b11, 2'b10, 0, 0, 0, 0);
    req = 2'b00;

    // Abort in SAMPLE, and in HOLD with a pending reseed.
    do_txn(2'b10, 2'b10, STEPS + 1, 0, 0, 0);
    do_txn(2'b01, 2'b01, STEPS + 2, 5, 0, 0);
    req = 2'b00;

    // Asynchronous reset in the middle of HOLD.
    req = 2'b01;
    tick();
    for (int i = 0; i < STEPS + 1; i++) tick();
    chk1("ar_valid", rnd_valid, 1'b1);
    ack = 2'b10;
    tick();
    chk1("ar_stray_valid", rnd_valid, 1'b1);
    chk2("ar_stray_grant", grant, 2'b01);
    ack = 2'b00;
    #2;
    aclr = 1'b0;
    #1;
    m_data = 6'd0;
    check_idle("ar_async");
    #2;
    aclr = 1'b1;
    req = 2'b00;
    m_lfsr = stepn(m_lfsr, STEPS);
    m_ptr = 1'b1;
    m_pend = 1'b0;
    tick();
    do_txn(2'b11, 2'b01, 0, 0, 0, 0);
    req = 2'b00;

    // Randomized transactions against the reference model.
    for (int n = 0; n < 40; n++) begin
      r = 2'($urandom_range(1, 3));
      ab = ($urandom_range(0, 3) == 0) ? int'($urandom_range(1, STEPS + 2)) : 0;
      rs = ($urandom_range(0, 3) == 0) ? int'($urandom_range(1, STEPS)) : 0;
      if (ab != 0 && rs >= ab) rs = 0;
      do_txn(r, arb(r, m_ptr), ab, rs, 0, int'($urandom_range(0, 3)));
      if ($urandom_range(0, 4) == 0) begin
        req = 2'b00;
        tick();
        check_idle("gap");
      end
    end
    req = 2'b00;
    tick();
    check_idle("final");

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
